// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: round-robin arbitration over writeback requesters,
// registered RF write stage, and a per-register pending-write scoreboard.
// Optional macro RF_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module rf_write_scheduler #(
  parameter int NREQ  = 3,
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int NREGS = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 we_RF,
  output logic [AW-1:0]        rd,
  output logic [DW-1:0]        WD3,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_ready,
  output logic [NREGS-1:0]     busy,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  function automatic logic legal(input logic [AW-1:0] a);
    return 32'(a) < 32'(NREGS);
  endfunction

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   sel;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            we_q;
  logic [1:0]      cnt     [NREGS];
  logic [1:0]      cnt_nxt [NREGS];
  logic [1:0]      cnt_rsv;
  logic            rsv_acc;
  logic            set_err;

  // Handshake: a transfer happens on requester i when req_valid[i] && req_ready[i];
  // req_ready is one-hot, combinational, and forced low during reset or freeze.
`ifdef RF_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    sel   = '0;
    xfer  = 1'b0;
    if (rst && arb_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!xfer && req_valid[i]) begin
          grant[i] = 1'b1;
          sel      = PW'(i);
          xfer     = 1'b1;
        end
      end
    end
  end
`else
  logic [PW-1:0] ptr;

  always_comb begin
    int idx;
    grant = '0;
    sel   = '0;
    xfer  = 1'b0;
    idx   = 0;
    if (rst && arb_en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!xfer && req_valid[idx]) begin
          grant[idx] = 1'b1;
          sel        = PW'(idx);
          xfer       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (32'(sel) == NREQ - 1) ? '0 : sel + PW'(1);
    end
  end
`endif

  assign req_ready = grant;
  assign sel_addr  = req_addr[sel*AW +: AW];
  assign sel_data  = req_data[sel*DW +: DW];

  // Illegal destinations are accepted and dropped here; only err records them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q <= 1'b0;
      rd   <= '0;
      WD3  <= '0;
    end else begin
      we_q <= xfer && legal(sel_addr);
      if (xfer) begin
        rd  <= sel_addr;
        WD3 <= sel_data;
      end
    end
  end

  // Gating with rst keeps a write held in the stage from reaching the RF during reset.
  assign we_RF = we_q && rst;

  always_comb begin
    cnt_rsv = 2'd0;
    for (int r = 0; r < NREGS; r++) begin
      if (rsv_addr == AW'(r)) cnt_rsv = cnt[r];
    end
  end

  assign rsv_ready = legal(rsv_addr) && (cnt_rsv != 2'd3);
  assign rsv_acc   = rsv_valid && rsv_ready;

  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt[r] = cnt[r];
      inc = rsv_acc && (rsv_addr == AW'(r));
      dec = we_q && (rd == AW'(r)) && (cnt[r] != 2'd0);
      if (inc && !dec)      cnt_nxt[r] = cnt[r] + 2'd1;
      else if (dec && !inc) cnt_nxt[r] = cnt[r] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= 2'd0;
      busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r]  <= cnt_nxt[r];
        busy[r] <= (cnt_nxt[r] != 2'd0);
      end
    end
  end

  assign set_err = (xfer && !legal(sel_addr)) || (rsv_valid && !legal(rsv_addr));

  always_ff @(posedge clk) begin
    if (!rst)         err <= 1'b0;
    else if (err_clr) err <= 1'b0;
    else if (set_err) err <= 1'b1;
  end

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Shares the register file's single write port between several writeback requesters (ALU, load unit, debug/host) with round-robin arbitration. It drives the register file's `we_RF`, `rd` and `WD3` inputs from a registered output stage. It also keeps a per-register pending-write scoreboard so the issue stage can stall reads of registers with outstanding writes. It sits between the execute/memory writeback paths and the register file.

## Interface
Parameters:
- NREQ, 3, number of write requesters (2..4)
- AW, 4, register address width
- DW, 32, data width
- NREGS, 15, implemented registers; addresses >= NREGS are illegal

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- arb_en  in  1  1 = grants allowed this cycle; 0 = no grant (pipeline freeze)
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid && ready
- we_RF  out  1  register file write enable
- rd  out  AW  register file write address
- WD3  out  DW  register file write data
- rsv_valid  in  1  issue stage reserves a future write to rsv_addr
- rsv_addr  in  AW  register being reserved
- rsv_ready  out  1  reservation accepted; 0 when rsv_addr counter is saturated
- busy  out  NREGS  bit r = 1 while register r has >= 1 pending write
- err  out  1  sticky: illegal address seen on a request or reservation
- err_clr  in  1  clears err

## Operation
- Arbitration: among `req_valid` bits, grant exactly one per cycle when `arb_en` = 1. The grant is combinational on `req_ready`.
- Round-robin: the search starts at `ptr`. After a grant to i, `ptr` becomes (i+1) mod NREQ. With no grant, `ptr` holds.
- Requester obligation: hold valid, addr and data stable until ready. Dropping valid before ready is legal; the request is simply lost.
- Output stage: a transfer in cycle N registers `we_RF` = 1, `rd` = addr and `WD3` = data, visible in cycle N+1. With no transfer, `we_RF` = 0 while `rd` and `WD3` hold their last values.
- Illegal address (>= NREGS) on a transfer: accept it (ready asserted), suppress `we_RF`, set `err`.
- Scoreboard: a 2-bit saturating pending counter per register, cnt[r].
  - Reservation accepted (rsv_valid && rsv_ready): cnt[rsv_addr]++.
  - Commit (`we_RF` = 1 in the output stage): cnt[rd]--, floored at 0.
  - busy[r] = (cnt[r] != 0), registered.
- `rsv_ready` = (cnt[rsv_addr] != 3) && (rsv_addr < NREGS). An illegal rsv_addr sets `err` and causes no counter change.
- Same-cycle reserve and commit to the same register: the counter is unchanged. Reserve is still refused if the counter is at 3.
- `err_clr` takes priority over a same-cycle error set: `err` = 0 after the edge.

## Timing
- Reset (rst = 0 at a rising edge): `we_RF` = 0, `rd` = 0, `WD3` = 0, `err` = 0, `busy` = 0, all counters 0, `ptr` = 0. `req_ready` = 0 while rst = 0.
- Reset mid-operation discards the output stage: a pending `we_RF` never reaches the register file. Pending scoreboard counts are lost.
- Latency: request accept to `we_RF` is 1 cycle. Commit to `busy` clear is 1 cycle, i.e. `busy` falls 2 cycles after the accept of the last pending write.
- Throughput: one write per cycle sustained. Any single requester gets a grant within NREQ cycles while `arb_en` = 1.
- Writes from the same requester commit in issue order. Across requesters, order follows grant order.
- `arb_en` = 0: `req_ready` = 0 that cycle, and the output stage still retires its held write (`we_RF` follows the previous cycle's transfer).

## Configuration
- RF_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and `ptr` is not implemented.
- Undefined (default): round-robin as above.
- Scoreboard and error behaviour are identical in both modes.

## Test plan
- Reset: hold rst = 0 for 2 cycles with req_valid = 3'b111 -> req_ready = 0, we_RF = 0, busy = 0, err = 0; first grant after release goes to requester 0.
- Round-robin: all three valid continuously, addrs 1/2/3 -> grants 0,1,2,0,...; we_RF = 1 every cycle with rd sequence 1,2,3,1 one cycle behind. Under RF_SCHED_FIXED_PRIO_EN, always requester 0.
- Scoreboard: reserve r5 twice (cnt = 2, busy[5] = 1), commit one write to r5 -> busy[5] still 1; second commit -> busy[5] = 0 one cycle after we_RF. A third and fourth reserve with no commit -> rsv_ready = 0 on the fourth.
- Simultaneous: reserve r7 in the same cycle we_RF commits r7 with cnt = 1 -> cnt stays 1, busy[7] = 1.
- Illegal address: requester 1 writes rd = 15 with data 32'hDEADBEEF -> accepted, we_RF stays 0, err = 1 and stays set; pulse err_clr -> err = 0.
- Freeze/reset: arb_en = 0 with requests pending -> no req_ready, and the previous write still retires. Assert rst in the cycle after an accept -> we_RF = 0 next cycle, no write.
